aes_block_feeder: RTL and testbench
===================================

// Module: aes_block_feeder
// PURPOSE
//  Word-stream front/back end for the AES-128 cipher core. Collects four 32-bit plaintext
//  words from an upstream valid/ready stream, loads the core (ld + key + 128-bit text),
//  and waits for done. It then captures the ciphertext and streams it out as four 32-bit words.
//  Sits directly between the system bus adapter and the cipher core; one block in flight.
// PARAMETERS
//  DONE_TIMEOUT  16  max cycles in RUN waiting for aes_done before abort (>=12)
// PORTS
//  clk           in   1    clock
//  rst           in   1    reset, asynchronous, active-high
//  key_in        in   128  cipher key; sampled in LOAD only
//  s_valid       in   1    upstream word valid
//  s_ready       out  1    upstream word accepted when s_valid&s_ready
//  s_data        in   32   plaintext word; first word -> bits [127:96]
//  m_valid       out  1    downstream ciphertext word valid
//  m_ready       in   1    downstream accept
//  m_data        out  32   ciphertext word; first word = bits [127:96]
//  m_last        out  1    high with 4th output word
//  aes_ld        out  1    one-cycle load strobe to core
//  aes_key       out  128  key to core (registered)
//  aes_text_in   out  128  plaintext to core (registered)
//  aes_done      in   1    core done pulse (1 cycle)
//  aes_text_out  in   128  core ciphertext; valid only in the aes_done cycle
//  err_timeout   out  1    sticky: a block was aborted on timeout
// BEHAVIOUR
//  Reset (async): state=FILL, word cnt=0, s_ready=1, m_valid=0, m_last=0, aes_ld=0,
//   aes_key/aes_text_in/m_data/capture reg=0, err_timeout=0.
//  FSM FILL->LOAD->RUN->DRAIN->FILL.
//  FILL: s_ready=1; each handshake shifts s_data into text reg; on 4th word -> LOAD.
//  LOAD (1 cycle): aes_ld=1, aes_key<=key_in in same edge as entry, so key and ld are
//   presented together; s_ready=0. -> RUN, timer cleared.
//  RUN: s_ready=0; timer++ each cycle. aes_done=1 -> capture aes_text_out, -> DRAIN.
//   Timer==DONE_TIMEOUT without done -> err_timeout<=1, block discarded, -> FILL.
//   Core nominal: done 11 cycles after aes_ld.
//  DRAIN: m_valid=1, m_data=capture word[idx]; idx advances only on m_valid&m_ready;
//   m_last=1 when idx==3; handshake at idx==3 -> FILL. m_data stable while stalled.
//  aes_done outside RUN: ignored. s_valid outside FILL: not accepted (s_ready=0).
//  Latency: 4th input handshake -> first m_valid = 1(LOAD)+~11(RUN)+1 = ~13 cycles.
//  Reset mid-operation: immediate return to reset state; partial words and capture lost.
//  err_timeout is cleared only by rst.
//  Throughput: no overlap; next block's FILL starts after DRAIN completes.
// CONFIGURATION
//  AES_FEEDER_STATS_EN defined: adds output blk_cnt[15:0], +1 per block fully drained.
//   Aborted blocks are not counted; it wraps 0xFFFF->0 and resets to 0.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package aes_feeder_pkg: typedef enum logic[1:0] {FILL,LOAD,RUN,DRAIN} feeder_state_t;
//   localparam WORDS_PER_BLK=4, WORD_W=32, BLK_W=128.
//  Single module. Core is instantiated by the parent, not inside this block.
// TESTING
//  FIPS-197 vector: key 000102..0e0f, 4 words 00112233,44556677,8899aabb,ccddeeff
//   -> out 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, m_last on 4th.
//  Back-to-back: 3 blocks with s_valid held high -> s_ready low from LOAD to end of DRAIN;
//   outputs in order, no drops.
//  Backpressure: m_ready=0 for 5 cycles at idx 1 -> m_data holds word1, m_valid stays 1.
//  Timeout: core model never pulses done -> after 16 RUN cycles err_timeout=1,
//   state FILL, m_valid never 1.
//  Reset in RUN: rst pulse at RUN cycle 5 -> all outputs to reset values;
//   a late aes_done is ignored; next block correct.
//  STATS_EN: 3 good blocks + 1 timeout -> blk_cnt=3.

Source files
------------

// File: rtl/aes_feeder_pkg.sv
// Shared types and constants for the AES-128 word-stream feeder.
// Provides the feeder FSM state type and a helper that picks one 32-bit word out of a block.
package aes_feeder_pkg;

    typedef enum logic [1:0] {FILL, LOAD, RUN, DRAIN} feeder_state_t;

    localparam int WORDS_PER_BLK = 4;
    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;

    // Word 0 is the most significant word of the block.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                   input logic [1:0]       idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = blk[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_block_feeder.sv
// Word-stream front/back end for an external AES-128 core: gathers 4 plaintext words,
// loads the core, captures the ciphertext and streams it out. Optional AES_FEEDER_STATS_EN adds blk_cnt.
module aes_block_feeder
    import aes_feeder_pkg::*;
#(
    parameter int DONE_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BLK_W-1:0]  key_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              aes_ld,
    output logic [BLK_W-1:0]  aes_key,
    output logic [BLK_W-1:0]  aes_text_in,
    input  logic              aes_done,
    input  logic [BLK_W-1:0]  aes_text_out,
    output logic              err_timeout
`ifdef AES_FEEDER_STATS_EN
    ,
    output logic [15:0]       blk_cnt
`endif
);

    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

    feeder_state_t    state_r;
    logic [1:0]       cnt_r;
    logic [1:0]       idx_r;
    logic [TMR_W-1:0] timer_r;
    logic [BLK_W-1:0] capture_r;

    // Feeder FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILL;
            cnt_r       <= 2'd0;
            idx_r       <= 2'd0;
            timer_r     <= '0;
            capture_r   <= '0;
            s_ready     <= 1'b1;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_data      <= '0;
            aes_ld      <= 1'b0;
            aes_key     <= '0;
            aes_text_in <= '0;
            err_timeout <= 1'b0;
        end else begin
            aes_ld <= 1'b0;
            case (state_r)
                FILL: begin
                    if (s_valid && s_ready) begin
                        aes_text_in <= {aes_text_in[BLK_W-WORD_W-1:0], s_data};
                        if (cnt_r == 2'd3) begin
                            // Key and load strobe reach the core on the same edge.
                            cnt_r   <= 2'd0;
                            aes_key <= key_in;
                            aes_ld  <= 1'b1;
                            s_ready <= 1'b0;
                            state_r <= LOAD;
                        end else begin
                            cnt_r <= cnt_r + 2'd1;
                        end
                    end
                end
                LOAD: begin
                    timer_r <= '0;
                    state_r <= RUN;
                end
                RUN: begin
                    if (aes_done) begin
                        capture_r <= aes_text_out;
                        m_data    <= word_sel(aes_text_out, 2'd0);
                        m_valid   <= 1'b1;
                        m_last    <= 1'b0;
                        idx_r     <= 2'd0;
                        state_r   <= DRAIN;
                    end else if (timer_r == TMR_W'(DONE_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        s_ready     <= 1'b1;
                        state_r     <= FILL;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (idx_r == 2'd3) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            state_r <= FILL;
                        end else begin
                            idx_r  <= idx_r + 2'd1;
                            m_data <= word_sel(capture_r, idx_r + 2'd1);
                            m_last <= (idx_r == 2'd2);
                        end
                    end
                end
                default: begin
                    state_r <= FILL;
                end
            endcase
        end
    end

`ifdef AES_FEEDER_STATS_EN
    logic drain_done_s;

    // A block counts only once its last word has been accepted downstream.
    always_comb begin
        drain_done_s = 1'b0;
        if ((state_r == DRAIN) && m_ready && (idx_r == 2'd3)) begin
            drain_done_s = 1'b1;
        end else begin
            drain_done_s = 1'b0;
        end
    end

    // Completed-block counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= 16'd0;
        end else if (drain_done_s) begin
            blk_cnt <= blk_cnt + 16'd1;
        end else begin
            blk_cnt <= blk_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_aes_block_feeder.sv
// Directed self-checking bench for aes_block_feeder with a behavioural core model
// (FIPS-197 vector known, otherwise ciphertext = plaintext ^ key).
module tb_aes_block_feeder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = 32'd0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [31:0]  m_data;
    logic         m_last;
    logic         aes_ld;
    logic [127:0] aes_key;
    logic [127:0] aes_text_in;
    logic         aes_done = 1'b0;
    logic [127:0] aes_text_out = 128'd0;
    logic         err_timeout;
`ifdef AES_FEEDER_STATS_EN
    logic [15:0]  blk_cnt;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int checks = 0;
    int passes = 0;

    aes_block_feeder #(.DONE_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .err_timeout  (err_timeout)
`ifdef AES_FEEDER_STATS_EN
        ,
        .blk_cnt      (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Core model: done pulse 11 cycles after it sees aes_ld; not affected by rst.
    bit           core_en = 1'b1;
    int           dcnt = 0;
    logic [127:0] res;
    always @(posedge clk) begin
        aes_done     <= 1'b0;
        aes_text_out <= 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) begin
                aes_done     <= 1'b1;
                aes_text_out <= res;
            end
        end
        if (aes_ld && core_en) begin
            dcnt = 11;
            res  = (aes_text_in == FIPS_PT && aes_key == FIPS_KEY) ? FIPS_CT : (aes_text_in ^ aes_key);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 64 && !s_ready; i++) step();
        if (!s_ready) begin
            checks++;
            $display("FAIL push_wait: s_ready=%b required 1", s_ready);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic push_block(input logic [127:0] blk);
        push_word(blk[127:96]);
        push_word(blk[95:64]);
        push_word(blk[63:32]);
        push_word(blk[31:0]);
    endtask

    task automatic drain_block;
        bit done;
        done = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (m_valid && m_last) done = 1'b1;
            step();
        end
        if (!done) begin
            checks++;
            $display("FAIL drain_wait: last word not seen");
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b need 1", s_ready); else passes++;
            checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b need 0", m_valid); else passes++;
            checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b need 0", m_last); else passes++;
            checks++; if (aes_ld !== 1'b0) $display("FAIL reset_aes_ld: got %b need 0", aes_ld); else passes++;
            checks++; if (aes_key !== 128'd0) $display("FAIL reset_aes_key: got %h need 0", aes_key); else passes++;
            checks++; if (aes_text_in !== 128'd0) $display("FAIL reset_text_in: got %h need 0", aes_text_in); else passes++;
            checks++; if (m_data !== 32'd0) $display("FAIL reset_m_data: got %h need 0", m_data); else passes++;
            checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b need 0", err_timeout); else passes++;
            if (k == 0) begin
                step();
                rst = 1'b0;
                step();
            end
        end
    endtask

    task automatic test_fips;
        logic [31:0] exp_w [4];
        exp_w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        push_block(FIPS_PT);
        checks++; if (aes_ld !== 1'b1) $display("FAIL fips_ld: got %b need 1", aes_ld); else passes++;
        checks++; if (aes_key !== FIPS_KEY) $display("FAIL fips_key: got %h need %h", aes_key, FIPS_KEY); else passes++;
        checks++; if (aes_text_in !== FIPS_PT) $display("FAIL fips_text: got %h need %h", aes_text_in, FIPS_PT); else passes++;
        checks++; if (s_ready !== 1'b0) $display("FAIL fips_s_ready_load: got %b need 0", s_ready); else passes++;
        key_in = 128'hffff;
        step();
        checks++; if (aes_ld !== 1'b0) $display("FAIL fips_ld_pulse: got %b need 0", aes_ld); else passes++;
        checks++; if (aes_key !== FIPS_KEY) $display("FAIL fips_key_hold: got %h need %h", aes_key, FIPS_KEY); else passes++;
        key_in = FIPS_KEY;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 40 && !m_valid; c++) step();
            checks++; if (m_data !== exp_w[i]) $display("FAIL fips_word%0d: got %h need %h", i, m_data, exp_w[i]); else passes++;
            checks++; if (m_last !== (i == 3)) $display("FAIL fips_last%0d: got %b need %b", i, m_last, (i == 3)); else passes++;
            step();
        end
        checks++; if (m_valid !== 1'b0) $display("FAIL fips_m_valid_end: got %b need 0", m_valid); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL fips_s_ready_end: got %b need 1", s_ready); else passes++;
    endtask

    task automatic test_backpressure;
        m_ready = 1'b1;
        push_block(128'h11111111_22222222_33333333_44444444);
        for (int c = 0; c < 40 && !m_valid; c++) step();
        checks++; if (m_data !== 32'h11101312) $display("FAIL bp_word0: got %h need 11101312", m_data); else passes++;
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b need 1", m_valid); else passes++;
            checks++; if (m_data !== 32'h26272425) $display("FAIL bp_data_hold: got %h need 26272425", m_data); else passes++;
            step();
        end
        m_ready = 1'b1;
        step();
        checks++; if (m_data !== 32'h3b3a3938) $display("FAIL bp_word2: got %h need 3b3a3938", m_data); else passes++;
        step();
        checks++; if (m_data !== 32'h48494a4b || m_last !== 1'b1) $display("FAIL bp_word3: got %h last %b need 48494a4b last 1", m_data, m_last); else passes++;
        step();
        checks++; if (m_valid !== 1'b0) $display("FAIL bp_end_valid: got %b need 0", m_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] in_w  [12];
        logic [31:0] exp_w [12];
        int in_idx, out_idx;
        bit hs_in, hs_out;
        in_w  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                  32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'hdddddddd};
        exp_w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a,
                  32'h11101312, 32'h26272425, 32'h3b3a3938, 32'h48494a4b,
                  32'haaaba8a9, 32'hbfbebdbc, 32'hc4c5c6c7, 32'hd1d0d3d2};
        in_idx = 0;
        out_idx = 0;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 500 && out_idx < 12; cyc++) begin
            s_valid = (in_idx < 12);
            s_data  = in_w[(in_idx < 12) ? in_idx : 11];
            hs_in   = s_valid && s_ready;
            hs_out  = m_valid && m_ready;
            if (hs_out) begin
                checks++; if (m_data !== exp_w[out_idx]) $display("FAIL b2b_word%0d: got %h need %h", out_idx, m_data, exp_w[out_idx]); else passes++;
                checks++; if (m_last !== ((out_idx % 4) == 3)) $display("FAIL b2b_last%0d: got %b", out_idx, m_last); else passes++;
            end
            if (m_valid || aes_ld) begin
                checks++; if (s_ready !== 1'b0) $display("FAIL b2b_s_ready_busy: got %b need 0", s_ready); else passes++;
            end
            step();
            if (hs_in) in_idx++;
            if (hs_out) out_idx++;
        end
        s_valid = 1'b0;
        checks++; if (out_idx != 12) $display("FAIL b2b_out_count: got %0d need 12", out_idx); else passes++;
        checks++; if (in_idx != 12) $display("FAIL b2b_in_count: got %0d need 12", in_idx); else passes++;
    endtask

    task automatic test_timeout;
        bit saw_valid;
        saw_valid = 1'b0;
        core_en = 1'b0;
        push_block(FIPS_PT);
        for (int i = 0; i < 16; i++) begin
            step();
            if (m_valid) saw_valid = 1'b1;
        end
        checks++; if (err_timeout !== 1'b0) $display("FAIL to_early: got %b need 0", err_timeout); else passes++;
        step();
        checks++; if (err_timeout !== 1'b1) $display("FAIL to_err: got %b need 1", err_timeout); else passes++;
        checks++; if (s_ready !== 1'b1) $display("FAIL to_fill: s_ready %b need 1", s_ready); else passes++;
        checks++; if (saw_valid || m_valid) $display("FAIL to_m_valid: got 1 need 0"); else passes++;
        core_en = 1'b1;
        m_ready = 1'b1;
        push_block(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd);
        for (int c = 0; c < 40 && !m_valid; c++) step();
        checks++; if (m_data !== 32'haaaba8a9) $display("FAIL to_next_word0: got %h need aaaba8a9", m_data); else passes++;
        drain_block();
        checks++; if (err_timeout !== 1'b1) $display("FAIL to_sticky: got %b need 1", err_timeout); else passes++;
    endtask

    task automatic test_reset_in_run;
        bit saw_valid;
        saw_valid = 1'b0;
        push_block(128'h11111111_22222222_33333333_44444444);
        repeat (5) step();
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || aes_ld !== 1'b0 || m_last !== 1'b0)
            $display("FAIL rr_ctrl: s_ready %b m_valid %b ld %b last %b need 1 0 0 0", s_ready, m_valid, aes_ld, m_last); else passes++;
        checks++; if (aes_key !== 128'd0 || aes_text_in !== 128'd0 || m_data !== 32'd0)
            $display("FAIL rr_data: key %h text %h m_data %h need zero", aes_key, aes_text_in, m_data); else passes++;
        checks++; if (err_timeout !== 1'b0) $display("FAIL rr_err: got %b need 0", err_timeout); else passes++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (m_valid) saw_valid = 1'b1;
        end
        checks++; if (saw_valid) $display("FAIL rr_late_done: m_valid 1 need 0"); else passes++;
        m_ready = 1'b1;
        push_block(FIPS_PT);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 40 && !m_valid; c++) step();
            checks++; if (m_data !== FIPS_CT[127-32*i -: 32]) $display("FAIL rr_next_word%0d: got %h need %h", i, m_data, FIPS_CT[127-32*i -: 32]); else passes++;
            step();
        end
    endtask

`ifdef AES_FEEDER_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (blk_cnt !== 16'd0) $display("FAIL stats_reset: got %0d need 0", blk_cnt); else passes++;
        push_block(FIPS_PT);
        drain_block();
        push_block(128'h11111111_22222222_33333333_44444444);
        drain_block();
        checks++; if (blk_cnt !== 16'd2) $display("FAIL stats_two: got %0d need 2", blk_cnt); else passes++;
        core_en = 1'b0;
        push_block(FIPS_PT);
        repeat (20) step();
        core_en = 1'b1;
        push_block(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd);
        drain_block();
        checks++; if (blk_cnt !== 16'd3) $display("FAIL stats_final: got %0d need 3", blk_cnt); else passes++;
    endtask
`endif

    initial begin
        key_in = FIPS_KEY;
        step();
        step();
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_in_run();
`ifdef AES_FEEDER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
